// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shift-scoreboard of in-flight destinations (EXE..WB)
// producing the ID stall and the EXE operand forwarding selects.
// Optional build macro HAZARD_STATS_EN adds stall_count / fwd_count outputs.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int SEL_W      = $clog2(PIPE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic                  mem_freeze,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use1,
    input  logic                  id_use2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    output logic                  hazard,
    output logic [SEL_W-1:0]      sel_src1,
    output logic [SEL_W-1:0]      sel_src2
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stall_count,
    output logic [31:0]           fwd_count
`endif
);

    // Scoreboard: index 0 = EXE, index PIPE_DEPTH-1 = WB.
    logic [PIPE_DEPTH-1:0] r_valid;
    logic [PIPE_DEPTH-1:0] r_wb_en;
    logic [REG_ADDR_W-1:0] r_dest [PIPE_DEPTH];
    // Only the EXE entry's load flag is ever consulted (load-use check), so
    // the flag is not carried down the older entries.
    logic                  r_mem_read0;

    logic [REG_ADDR_W-1:0] r_exe_src1;
    logic [REG_ADDR_W-1:0] r_exe_src2;
    logic                  r_exe_use1;
    logic                  r_exe_use2;

    logic                  w_raw_hazard;
    logic                  w_bubble;

    assign w_bubble = hazard | flush;

    // Shift the scoreboard one stage per unfrozen edge; load ID into EXE or a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= '0;
            r_wb_en     <= '0;
            r_mem_read0 <= 1'b0;
            for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
                r_dest[k] <= '0;
            end
            r_exe_src1  <= '0;
            r_exe_src2  <= '0;
            r_exe_use1  <= 1'b0;
            r_exe_use2  <= 1'b0;
        end else if (!mem_freeze) begin
            r_valid     <= {r_valid[PIPE_DEPTH-2:0], ~w_bubble};
            r_wb_en     <= {r_wb_en[PIPE_DEPTH-2:0], id_wb_en};
            r_mem_read0 <= id_mem_read;
            for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
                r_dest[k] <= r_dest[k-1];
            end
            r_dest[0]   <= id_dest;
            r_exe_src1  <= id_src1;
            r_exe_src2  <= id_src2;
            r_exe_use1  <= id_use1 & ~w_bubble;
            r_exe_use2  <= id_use2 & ~w_bubble;
        end
    end

    // ID stall: any RAW in stall-only mode, load-use only in forwarding mode
    always_comb begin
        w_raw_hazard = 1'b0;
        if (forward_en) begin
            w_raw_hazard = r_valid[0] && r_wb_en[0] && r_mem_read0 &&
                           ((id_use1 && (r_dest[0] == id_src1)) ||
                            (id_use2 && (r_dest[0] == id_src2)));
        end else begin
            // WB entry excluded: the register file writes during that cycle.
            for (int unsigned k = 0; k < PIPE_DEPTH - 1; k++) begin
                if (r_valid[k] && r_wb_en[k] &&
                    ((id_use1 && (r_dest[k] == id_src1)) ||
                     (id_use2 && (r_dest[k] == id_src2)))) begin
                    w_raw_hazard = 1'b1;
                end
            end
        end
        hazard = w_raw_hazard & ~flush;
    end

    // Forwarding selects: youngest matching producer among entries 1..PIPE_DEPTH-1
    always_comb begin
        sel_src1 = '0;
        sel_src2 = '0;
        if (forward_en) begin
            // Walk oldest to youngest so the youngest match is written last.
            for (int unsigned k = PIPE_DEPTH - 1; k >= 1; k--) begin
                if (r_exe_use1 && r_valid[k] && r_wb_en[k] && (r_dest[k] == r_exe_src1)) begin
                    sel_src1 = SEL_W'(k);
                end
                if (r_exe_use2 && r_valid[k] && r_wb_en[k] && (r_dest[k] == r_exe_src2)) begin
                    sel_src2 = SEL_W'(k);
                end
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_fwd_count;

    // Count stalled and forwarding cycles on advancing edges only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_fwd_count   <= '0;
        end else if (!mem_freeze) begin
            if (hazard && !flush) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if ((sel_src1 != '0) || (sel_src2 != '0)) begin
                r_fwd_count <= r_fwd_count + 32'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign fwd_count   = r_fwd_count;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters).
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       forward_en = 1'b0;
    logic       mem_freeze = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] id_src1 = '0;
    logic [3:0] id_src2 = '0;
    logic       id_use1 = 1'b0;
    logic       id_use2 = 1'b0;
    logic [3:0] id_dest = '0;
    logic       id_wb_en = 1'b0;
    logic       id_mem_read = 1'b0;
    logic       hazard;
    logic [1:0] sel_src1;
    logic [1:0] sel_src2;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count;
    logic [31:0] fwd_count;
`endif

    int checks = 0;
    int failures = 0;

    hazard_scoreboard #(.REG_ADDR_W(4), .PIPE_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .mem_freeze(mem_freeze),
        .flush(flush), .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1),
        .id_use2(id_use2), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .hazard(hazard), .sel_src1(sel_src1),
        .sel_src2(sel_src2)
`ifdef HAZARD_STATS_EN
        , .stall_count(stall_count), .fwd_count(fwd_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                         input logic u2, input logic [3:0] d, input logic wb, input logic mr);
        id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
        id_dest = d; id_wb_en = wb; id_mem_read = mr;
        #1;
    endtask

    task automatic drive_nop();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        flush = 1'b0; mem_freeze = 1'b0;
        drive_nop();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        forward_en = 1'b0;
        drive(4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
        forward_en = 1'b1; #1;
        checks++; if (sel_src1 !== 2'd0) begin failures++; $display("FAIL reset_sel1 got=%0d exp=0", sel_src1); end
        checks++; if (sel_src2 !== 2'd0) begin failures++; $display("FAIL reset_sel2 got=%0d exp=0", sel_src2); end
        do_reset();
    endtask

    task automatic test_stall_only();
        do_reset();
        forward_en = 1'b0;
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);       // ADD r1
        tick();
        drive(4'd1, 1'b1, 4'd2, 1'b0, 4'd4, 1'b1, 1'b0);       // SUB r4, r1
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL stall_c1 got=%b exp=1", hazard); end
        tick();
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL stall_c2 got=%b exp=1", hazard); end
        tick();
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL stall_c3 got=%b exp=0", hazard); end
        tick();
        drive_nop();
        checks++; if (sel_src1 !== 2'd0) begin failures++; $display("FAIL stall_sel1 got=%0d exp=0", sel_src1); end
    endtask

    task automatic test_forwarding();
        do_reset();
        forward_en = 1'b1;
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);       // ADD r1
        tick();
        drive(4'd1, 1'b1, 4'd2, 1'b0, 4'd4, 1'b1, 1'b0);       // SUB reads r1
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL fwd1_hazard got=%b exp=0", hazard); end
        tick();
        drive_nop();
        checks++; if (sel_src1 !== 2'd1) begin failures++; $display("FAIL fwd1_sel1 got=%0d exp=1", sel_src1); end

        do_reset();
        forward_en = 1'b1;
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);       // ADD r1
        tick();
        drive_nop();                                           // NOP
        tick();
        drive(4'd1, 1'b1, 4'd2, 1'b0, 4'd4, 1'b1, 1'b0);       // SUB reads r1
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL fwd2_hazard got=%b exp=0", hazard); end
        tick();
        drive_nop();
        checks++; if (sel_src1 !== 2'd2) begin failures++; $display("FAIL fwd2_sel1 got=%0d exp=2", sel_src1); end
    endtask

    task automatic test_load_use();
        do_reset();
        forward_en = 1'b1;
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);       // LDR r2
        tick();
        drive(4'd2, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0);       // ADD reads r2
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL lu_c1 got=%b exp=1", hazard); end
        tick();
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL lu_c2 got=%b exp=0", hazard); end
        checks++; if (sel_src1 !== 2'd0) begin failures++; $display("FAIL lu_bubble_sel1 got=%0d exp=0", sel_src1); end
        tick();
        drive_nop();
        checks++; if (sel_src1 !== 2'd2) begin failures++; $display("FAIL lu_sel1 got=%0d exp=2", sel_src1); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        forward_en = 1'b1;
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);       // older writer r3
        tick();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);       // younger writer r3
        tick();
        drive(4'd3, 1'b1, 4'd3, 1'b1, 4'd9, 1'b1, 1'b0);       // reads r3 twice
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL b2b_hazard got=%b exp=0", hazard); end
        tick();
        drive_nop();
        checks++; if (sel_src2 !== 2'd1) begin failures++; $display("FAIL b2b_sel2 got=%0d exp=1", sel_src2); end
        checks++; if (sel_src1 !== 2'd1) begin failures++; $display("FAIL b2b_sel1 got=%0d exp=1", sel_src1); end
    endtask

    task automatic test_flush_freeze();
        do_reset();
        forward_en = 1'b1;
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);       // LDR r5
        tick();
        flush = 1'b1;
        drive(4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);       // load-use, but flushed
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL flush_hazard got=%b exp=0", hazard); end
        tick();
        flush = 1'b0;
        drive(4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);       // reader of r5
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b exp=0", hazard); end
        tick();
        mem_freeze = 1'b1;
        drive_nop();
        checks++; if (sel_src1 !== 2'd2) begin failures++; $display("FAIL pre_freeze_sel1 got=%0d exp=2", sel_src1); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (sel_src1 !== 2'd2) begin failures++; $display("FAIL freeze_sel1 cyc=%0d got=%0d exp=2", c, sel_src1); end
            checks++; if (sel_src2 !== 2'd0) begin failures++; $display("FAIL freeze_sel2 cyc=%0d got=%0d exp=0", c, sel_src2); end
        end
        mem_freeze = 1'b0;
        #1;
    endtask

    task automatic test_midstream_reset();
        do_reset();
        forward_en = 1'b1;
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick();
        drive(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        tick();
        drive(4'd7, 1'b1, 4'd6, 1'b1, 4'd8, 1'b1, 1'b0);
        tick();
        drive(4'd8, 1'b1, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
        checks++; if (sel_src1 !== 2'd1) begin failures++; $display("FAIL mid_sel1 got=%0d exp=1", sel_src1); end
        checks++; if (sel_src2 !== 2'd2) begin failures++; $display("FAIL mid_sel2 got=%0d exp=2", sel_src2); end
        forward_en = 1'b0; #1;
        checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL mid_pre_hazard got=%b exp=1", hazard); end
        rst = 1'b1; #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL mid_rst_hazard got=%b exp=0", hazard); end
        forward_en = 1'b1; #1;
        checks++; if (sel_src1 !== 2'd0) begin failures++; $display("FAIL mid_rst_sel1 got=%0d exp=0", sel_src1); end
        checks++; if (sel_src2 !== 2'd0) begin failures++; $display("FAIL mid_rst_sel2 got=%0d exp=0", sel_src2); end
`ifdef HAZARD_STATS_EN
        checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL mid_rst_stall_count got=%0d exp=0", stall_count); end
        checks++; if (fwd_count !== 32'd0) begin failures++; $display("FAIL mid_rst_fwd_count got=%0d exp=0", fwd_count); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        forward_en = 1'b0; #1;
        checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL post_rst_hazard got=%b exp=0", hazard); end
    endtask

    initial begin
        test_reset();
        test_stall_only();
        test_forwarding();
        test_load_use();
        test_back_to_back();
        test_flush_freeze();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
